// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port indices for the two-port memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  localparam int PORT_IF = 0;
  localparam int PORT_LS = 1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the port that did not win last time is chosen
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);
  // a lone requester always wins; a tie goes to the port other than last_grant
  always_comb begin
    grant_valid = |req;
    grant_idx   = (&req) ? ~last_grant : req[1];
  end
endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one single-port memory between instruction fetch (port 0) and load/store (port 1)
import mem_arb_pkg::*;
module mem_arbiter2 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);
  arb_state_e            r_state, w_next;
  logic                  r_owner, r_we, r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic                  w_grant_valid, w_grant_idx;

  rr_pick2 u_pick (
    .req         (req),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  // state register; reset drops straight to IDLE so every decoded output goes low at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next state and output decode; mem_resp only matters while BUSY
  always_comb begin
    w_next    = (r_state == IDLE) ? (w_grant_valid ? BUSY : IDLE) :
                (r_state == BUSY) ? (mem_resp ? RESP : BUSY) : IDLE;
    ack       = (r_state == RESP) ? ((r_owner == 1'(PORT_LS)) ? 2'b10 : 2'b01) : 2'b00;
    rdata     = (r_state == RESP) ? r_rdata : '0;
    mem_read  = (r_state == BUSY) & ~r_we;
    mem_write = (r_state == BUSY) & r_we;
    mem_addr  = (r_state == BUSY) ? r_addr : '0;
    mem_wdata = (r_state == BUSY) ? r_wdata : '0;
  end

  // command capture at grant, read data capture at resp, fairness pointer update at ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (r_state == IDLE && w_grant_valid) begin
        r_owner <= w_grant_idx;
        r_we    <= we[w_grant_idx];
        r_addr  <= w_grant_idx ? addr1 : addr0;
        r_wdata <= w_grant_idx ? wdata1 : wdata0;
      end
      if (r_state == BUSY && mem_resp) r_rdata <= r_we ? '0 : mem_rdata;
      if (r_state == RESP) r_last_grant <= r_owner;
    end
  end
endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed scenarios against a small RAM model with a stretchable resp
module tb_mem_arbiter2;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = 2'b00, we = 2'b00;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [1:0] ack;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic       mem_read, mem_write, mem_resp;
  logic [3:0] mem_addr;
  logic [7:0] mem [16];
  int         hold = 0, busy_cyc = 0;
  logic       kick = 1'b0;
  int         err = 0, chk = 0;

  mem_arbiter2 #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .rdata(rdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // zero-delay RAM; resp is held low for the first `hold` cycles of each access
  assign mem_rdata = mem[mem_addr];
  assign mem_resp  = ((mem_read | mem_write) && busy_cyc >= hold) || kick;
  always @(posedge clk) begin
    busy_cyc <= (mem_read | mem_write) ? busy_cyc + 1 : 0;
    if (mem_write && mem_resp) mem[mem_addr] <= mem_wdata;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    chk++; if ({ack, rdata, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin err++; $display("FAIL reset_outputs got ack=%b rdata=%h rd=%b wr=%b addr=%h wd=%h want all 0", ack, rdata, mem_read, mem_write, mem_addr, mem_wdata); end
    step; step;
    rst_n = 1'b1;
    step;
    chk++; if ({ack, mem_read, mem_write} !== '0) begin err++; $display("FAIL idle_outputs got ack=%b rd=%b wr=%b want 0", ack, mem_read, mem_write); end
  endtask

  task automatic test_read;
    req = 2'b01; we = 2'b00; addr0 = 4'd3;
    step;
    chk++; if ({mem_read, mem_write, mem_addr, ack} !== {1'b1, 1'b0, 4'd3, 2'b00}) begin err++; $display("FAIL read_busy got rd=%b wr=%b addr=%h ack=%b want 1 0 3 00", mem_read, mem_write, mem_addr, ack); end
    step;
    chk++; if ({ack, rdata, mem_read} !== {2'b01, 8'hA5, 1'b0}) begin err++; $display("FAIL read_ack got ack=%b rdata=%h rd=%b want 01 a5 0", ack, rdata, mem_read); end
    req = 2'b00;
    step;
    chk++; if (ack !== 2'b00) begin err++; $display("FAIL read_ack_pulse got %b want 00", ack); end
  endtask

  task automatic test_write_read;
    req = 2'b10; we = 2'b10; addr1 = 4'd9; wdata1 = 8'h5A;
    step;
    chk++; if ({mem_read, mem_write, mem_addr, mem_wdata} !== {1'b0, 1'b1, 4'd9, 8'h5A}) begin err++; $display("FAIL write_busy got rd=%b wr=%b addr=%h wd=%h want 0 1 9 5a", mem_read, mem_write, mem_addr, mem_wdata); end
    step;
    chk++; if ({ack, rdata} !== {2'b10, 8'h00}) begin err++; $display("FAIL write_ack got ack=%b rdata=%h want 10 00", ack, rdata); end
    req = 2'b00; we = 2'b00;
    step;
    req = 2'b10;
    step; step;
    chk++; if ({ack, rdata} !== {2'b10, 8'h5A}) begin err++; $display("FAIL readback got ack=%b rdata=%h want 10 5a", ack, rdata); end
    req = 2'b00;
    step;
  endtask

  task automatic test_alternate;
    logic [1:0] exp_ack;
    logic [7:0] exp_rd;
    addr0 = 4'd3; addr1 = 4'd7; we = 2'b00; req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      step;
      exp_ack = (c % 3 == 2) ? (((c / 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_rd  = (exp_ack == 2'b01) ? 8'hA5 : (exp_ack == 2'b10) ? 8'h3C : 8'h00;
      chk++; if ({ack, rdata} !== {exp_ack, exp_rd}) begin err++; $display("FAIL alternate_c%0d got ack=%b rdata=%h want %b %h", c, ack, rdata, exp_ack, exp_rd); end
      chk++; if (mem_read & mem_write) begin err++; $display("FAIL alternate_rdwr_c%0d got rd=1 wr=1 want not both", c); end
    end
    req = 2'b00;
    step;
  endtask

  task automatic test_stretch;
    hold = 4; req = 2'b01; we = 2'b00; addr0 = 4'd7;
    for (int i = 0; i < 5; i++) begin
      step;
      chk++; if ({mem_read, mem_write, mem_addr, ack} !== {1'b1, 1'b0, 4'd7, 2'b00}) begin err++; $display("FAIL stretch_busy%0d got rd=%b wr=%b addr=%h ack=%b want 1 0 7 00", i, mem_read, mem_write, mem_addr, ack); end
    end
    step;
    chk++; if ({ack, rdata} !== {2'b01, 8'h3C}) begin err++; $display("FAIL stretch_ack got ack=%b rdata=%h want 01 3c", ack, rdata); end
    req = 2'b00; hold = 0;
    step;
  endtask

  task automatic test_latch;
    req = 2'b01; we = 2'b00; addr0 = 4'd3;
    step;
    addr0 = 4'd7;
    #1;
    chk++; if (mem_addr !== 4'd3) begin err++; $display("FAIL latch_addr got %h want 3", mem_addr); end
    step;
    chk++; if ({ack, rdata} !== {2'b01, 8'hA5}) begin err++; $display("FAIL latch_ack got ack=%b rdata=%h want 01 a5", ack, rdata); end
    req = 2'b00;
    step;
  endtask

  task automatic test_resp_idle;
    kick = 1'b1;
    step;
    kick = 1'b0;
    chk++; if ({ack, mem_read, mem_write} !== '0) begin err++; $display("FAIL resp_idle got ack=%b rd=%b wr=%b want 0", ack, mem_read, mem_write); end
    step;
    chk++; if (ack !== 2'b00) begin err++; $display("FAIL resp_idle_ack got %b want 00", ack); end
  endtask

  task automatic test_abandon;
    hold = 2; req = 2'b10; we = 2'b00; addr1 = 4'd7; addr0 = 4'd3;
    step;
    req = 2'b11;
    step;
    req = 2'b10;
    step;
    step;
    chk++; if ({ack, rdata} !== {2'b10, 8'h3C}) begin err++; $display("FAIL abandon_p1_ack got ack=%b rdata=%h want 10 3c", ack, rdata); end
    req = 2'b00; hold = 0;
    step; step;
    chk++; if ({ack, mem_read, mem_write} !== '0) begin err++; $display("FAIL abandon_p0 got ack=%b rd=%b wr=%b want 0", ack, mem_read, mem_write); end
  endtask

  task automatic test_reset_busy;
    hold = 3; req = 2'b10; we = 2'b10; addr1 = 4'd9; wdata1 = 8'hFF;
    step;
    chk++; if (mem_write !== 1'b1) begin err++; $display("FAIL rstbusy_write got %b want 1", mem_write); end
    rst_n = 1'b0;
    #1;
    chk++; if ({ack, rdata, mem_read, mem_write, mem_addr, mem_wdata} !== '0) begin err++; $display("FAIL rstbusy_outputs got ack=%b rdata=%h rd=%b wr=%b addr=%h wd=%h want all 0", ack, rdata, mem_read, mem_write, mem_addr, mem_wdata); end
    req = 2'b00; we = 2'b00;
    step;
    chk++; if (ack !== 2'b00) begin err++; $display("FAIL rstbusy_ack got %b want 00", ack); end
    rst_n = 1'b1; hold = 0;
    step;
    req = 2'b10; addr1 = 4'd9;
    step;
    chk++; if ({mem_read, mem_addr} !== {1'b1, 4'd9}) begin err++; $display("FAIL rstbusy_restart got rd=%b addr=%h want 1 9", mem_read, mem_addr); end
    step;
    chk++; if ({ack, rdata} !== {2'b10, 8'h5A}) begin err++; $display("FAIL rstbusy_old_value got ack=%b rdata=%h want 10 5a", ack, rdata); end
    req = 2'b00;
    step;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[3] = 8'hA5;
    mem[7] = 8'h3C;
    test_reset;
    test_read;
    test_write_read;
    test_alternate;
    test_stretch;
    test_latch;
    test_resp_idle;
    test_abandon;
    test_reset_busy;
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
